// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared types and constants for the divide sequencer.
//   REG_BUS / ZERO_WORD      : architectural register width and zero value
//   div_state_e              : sequencer states (2-bit encoding)
//   DIV_RESULT_(NOT_)READY   : ready_o levels
//   DIV_START / DIV_STOP     : start_i levels
//   abs_op()                 : magnitude of an operand, two's-complement only when signed
package div_seq_pkg;

   localparam int REG_BUS = 32;
   localparam int WORK_W  = 2 * REG_BUS + 1;   // {rem[32:0], quo[31:0]}

   localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   function automatic logic [REG_BUS-1:0] abs_op(input logic [REG_BUS-1:0] v,
                                                 input logic              signed_en);
      return (signed_en && v[REG_BUS-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle between EX and the divide sequencer.
//   master (EX side)    : drives start_i, annul_i, signed_div_i, rem_sel_i, opdata1_i, opdata2_i
//                         receives result_o, ready_o, busy_o
//   slave (div_seq side): the mirror image
interface div_seq_if;
   import div_seq_pkg::*;

   logic               start_i;
   logic               annul_i;
   logic               signed_div_i;
   logic               rem_sel_i;
   logic [REG_BUS-1:0] opdata1_i;
   logic [REG_BUS-1:0] opdata2_i;
   logic [REG_BUS-1:0] result_o;
   logic               ready_o;
   logic               busy_o;

   modport master (
      output start_i, annul_i, signed_div_i, rem_sel_i, opdata1_i, opdata2_i,
      input  result_o, ready_o, busy_o
   );

   modport slave (
      input  start_i, annul_i, signed_div_i, rem_sel_i, opdata1_i, opdata2_i,
      output result_o, ready_o, busy_o
   );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational iteration of radix-2 restoring division.
//   work      in  65  current {rem[32:0], quo[31:0]}
//   divisor   in  32  divisor magnitude
//   work_next out 65  register after shift, trial subtract and quotient-bit insert
module div_step
   import div_seq_pkg::*;
(
   input  logic [WORK_W-1:0]  work,
   input  logic [REG_BUS-1:0] divisor,
   output logic [WORK_W-1:0]  work_next
);

   logic [WORK_W-1:0] shifted;
   logic [REG_BUS+1:0] trial;   // one extra bit so the borrow is the sign

   assign shifted = {work[WORK_W-2:0], 1'b0};
   assign trial   = {1'b0, shifted[WORK_W-1:REG_BUS]} - {2'b00, divisor};

   always_comb begin
      work_next = shifted;
      if (!trial[REG_BUS+1]) begin
         work_next = {trial[REG_BUS:0], shifted[REG_BUS-1:1], 1'b1};
      end
   end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle sequencer for RISC-V DIV/DIVU/REM/REMU.
//   clk  in  core clock
//   rst  in  synchronous active-high reset
//   bus  div_seq_if.slave: start/annul/mode/operands in, result/ready/busy out
// Radix-2 restoring division, one quotient bit per cycle (33-cycle latency).
// Build option: define DIV_EARLY_OUT_EN to route divide-by-zero and signed
// overflow through DIV_BY_ZERO for a 2-cycle result; otherwise every
// operation goes through DIV_ON and the same corrected result comes out.
module div_seq
   import div_seq_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   div_seq_if.slave bus
);

   div_state_e          state_q, state_d;
   logic [4:0]          cnt_q;
   logic [WORK_W-1:0]   work_q, work_step;
   logic [REG_BUS-1:0]  dvs_q, op1_q;
   logic                signed_q, rem_sel_q, neg1_q, neg2_q, div0_q, ovf_q;
   logic                accept, div0_in, ovf_in, ready;
   logic [REG_BUS-1:0]  quo_mag, rem_mag, quo_fix, rem_fix;
   logic                unused_rem_msb;

   assign accept  = (state_q == DIV_FREE) && (bus.start_i == DIV_START) && !bus.annul_i;
   assign div0_in = (bus.opdata2_i == ZERO_WORD);
   assign ovf_in  = bus.signed_div_i && (bus.opdata1_i == 32'h8000_0000)
                    && (bus.opdata2_i == 32'hFFFF_FFFF);

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= DIV_FREE;
      else     state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_FREE: begin
            if (accept) begin
`ifdef DIV_EARLY_OUT_EN
               state_d = (div0_in || ovf_in) ? DIV_BY_ZERO : DIV_ON;
`else
               state_d = DIV_ON;
`endif
            end
         end
         DIV_BY_ZERO: state_d = bus.annul_i ? DIV_FREE : DIV_END;
         DIV_ON: begin
            if (bus.annul_i)          state_d = DIV_FREE;
            else if (cnt_q == 5'd31)  state_d = DIV_END;
         end
         DIV_END: begin
            // hold the result until EX drops its request
            if (bus.start_i == DIV_STOP) state_d = DIV_FREE;
         end
         default: state_d = DIV_FREE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         work_q    <= '0;
         dvs_q     <= '0;
         op1_q     <= '0;
         signed_q  <= 1'b0;
         rem_sel_q <= 1'b0;
         neg1_q    <= 1'b0;
         neg2_q    <= 1'b0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (accept) begin
         // operands are captured once here; EX may change them afterwards
         cnt_q     <= '0;
         work_q    <= {{(REG_BUS+1){1'b0}}, abs_op(bus.opdata1_i, bus.signed_div_i)};
         dvs_q     <= abs_op(bus.opdata2_i, bus.signed_div_i);
         op1_q     <= bus.opdata1_i;
         signed_q  <= bus.signed_div_i;
         rem_sel_q <= bus.rem_sel_i;
         neg1_q    <= bus.opdata1_i[REG_BUS-1];
         neg2_q    <= bus.opdata2_i[REG_BUS-1];
         div0_q    <= div0_in;
         ovf_q     <= ovf_in;
      end else if (state_q == DIV_ON && !bus.annul_i) begin
         work_q <= work_step;
         cnt_q  <= cnt_q + 5'd1;
      end
   end

   div_step u_step (
      .work      (work_q),
      .divisor   (dvs_q),
      .work_next (work_step)
   );

   // ---------------- result correction ----------------
   assign quo_mag        = work_q[REG_BUS-1:0];
   assign rem_mag        = work_q[2*REG_BUS-1:REG_BUS];
   assign unused_rem_msb = work_q[WORK_W-1];   // always 0 once all steps are done

   // Corner cases are forced from the latched flags, so the early-out path
   // (which never runs the iterations) yields the same values as the full one.
   always_comb begin
      quo_fix = (signed_q && (neg1_q ^ neg2_q)) ? (~quo_mag + 1'b1) : quo_mag;
      rem_fix = (signed_q && neg1_q)            ? (~rem_mag + 1'b1) : rem_mag;
      if (div0_q) begin
         quo_fix = 32'hFFFF_FFFF;
         rem_fix = op1_q;
      end else if (ovf_q) begin
         quo_fix = 32'h8000_0000;
         rem_fix = ZERO_WORD;
      end
   end

   assign ready        = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
   assign bus.ready_o  = ready;
   assign bus.result_o = ready ? (rem_sel_q ? rem_fix : quo_fix) : ZERO_WORD;
   // drops the same cycle ready rises so EX advances with the result
   assign bus.busy_o   = bus.start_i & ~ready;

endmodule
